// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first, start/busy/done handshake.
// Optional macro DIV_ZERO_DETECT_EN: divisor 0 short-circuits to a 1-cycle result and raises div_by_zero.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
`ifdef DIV_ZERO_DETECT_EN
  localparam logic [1:0] ST_DZERO = 2'd2;
`endif

  logic [1:0]            state_q, state_d;
  // Shift register: unconsumed dividend bits leave at the top, quotient bits enter at the bottom.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_out_q, quo_out_d;
  logic [DIVISOR_W-1:0]  rem_out_q, rem_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    r_shift;
  logic                  q_bit;
  logic [DIVISOR_W-1:0]  r_next;
  logic [DIVIDEND_W-1:0] q_shift;

  // The stored partial remainder is always < divisor, so only its low bits are kept;
  // the extra bit lives only in the shifted compare value.
  always_comb begin
    r_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
    q_bit   = (r_shift >= {1'b0, dsr_q});
    r_next  = q_bit ? (r_shift[DIVISOR_W-1:0] - dsr_q) : r_shift[DIVISOR_W-1:0];
    q_shift = (dvd_q << 1) | DIVIDEND_W'(q_bit);
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dsr_d = divisor;
          rem_d = '0;
          cnt_d = CNT_W'(DIVIDEND_W);
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            state_d = ST_DZERO;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
          end
`else
          state_d = ST_RUN;
          busy_d  = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        dvd_d = q_shift;
        rem_d = r_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          quo_out_d = q_shift;
          rem_out_d = r_next;
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      ST_DZERO: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        quo_out_d = '1;
        rem_out_d = dvd_q[DIVISOR_W-1:0];
        dbz_d     = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient  = quo_out_q;
  assign remainder = rem_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0 & dbz_q;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks for seq_restoring_divider (8-bit / 4-bit defaults).
module tb_seq_restoring_divider;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_fail = 0;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    int         lat;
    int         busy_n;
    logic       dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after the start edge; returns #1 after the edge where done is seen.
  // lat = 99 flags a timeout.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_n++;
    end
    if (!done) lat = 99;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b;
    wait_done(lat, busy_n);
  endtask

  initial begin
    int lat, bn, pulses;

    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  8, 8, 1'b0};
    vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  8, 8, 1'b0};
    vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  8, 8, 1'b0};
    vecs[3] = '{8'd0,   4'd1,  8'd0,   4'd0,  8, 8, 1'b0};
    vecs[4] = '{8'hA6,  4'd0,  8'hFF,  4'h6,  ZD ? 1 : 8, ZD ? 0 : 8, ZD};
    vecs[5] = '{8'd1,   4'd1,  8'd1,   4'd0,  8, 8, 1'b0};
    vecs[6] = '{8'd255, 4'd1,  8'd255, 4'd0,  8, 8, 1'b0};
    vecs[7] = '{8'd254, 4'd15, 8'd16,  4'd14, 8, 8, 1'b0};
    vecs[8] = '{8'd128, 4'd3,  8'd42,  4'd2,  8, 8, 1'b0};
    vecs[9] = '{8'd99,  4'd10, 8'd9,   4'd9,  8, 8, 1'b0};

    #1;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, bn);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_busy_cycles", i), bn, vecs[i].busy_n);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_width", i), done, 0);
      chk($sformatf("v%0d_hold_q", i), quotient, vecs[i].q);
    end

    // Mid-run start request must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    bn = busy ? 1 : 0;
    lat = 0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (lat == 0) lat = c;
      end else if (lat == 0 && busy) begin
        bn++;
      end
      if (lat == 0 && c != 8 && !done) chk($sformatf("t4_q_hold_c%0d", c), quotient, 9);
      if (c == 8) begin
        chk("t4_quotient", quotient, 33);
        chk("t4_remainder", remainder, 1);
      end
    end
    chk("t4_latency", lat, 8);
    chk("t4_busy_cycles", bn, 8);
    chk("t4_done_pulses", pulses, 1);

    // Back-to-back: new start in the done cycle.
    do_op(8'd9, 4'd2, lat, bn);
    chk("t5a_latency", lat, 8);
    chk("t5a_quotient", quotient, 4);
    chk("t5a_remainder", remainder, 1);
    start = 1'b1; dividend = 8'd77; divisor = 4'd6;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    chk("t5_busy_after_accept", busy, 1);
    wait_done(lat, bn);
    chk("t5b_latency", lat, 8);
    chk("t5b_quotient", quotient, 12);
    chk("t5b_remainder", remainder, 5);

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1; dividend = 8'd123; divisor = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t6_rst_quotient", quotient, 0);
    chk("t6_rst_remainder", remainder, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("t6_no_done_after_reset", pulses, 0);
    do_op(8'd123, 4'd4, lat, bn);
    chk("t6_latency", lat, 8);
    chk("t6_quotient", quotient, 30);
    chk("t6_remainder", remainder, 3);

    // Exhaustive nonzero-divisor sweep against the language's / and %.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a), 4'(b), lat, bn);
        chk($sformatf("sweep_%0d_%0d", a, b), {lat[7:0], quotient, 4'd0, remainder},
            {8'd8, 8'(a / b), 4'd0, 4'(a % b)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
